// File: rtl/ceiling_arb_pkg.sv
// ceiling_arb_pkg
// Shared definitions for the ceiling arbiter:
//   state_e  - EMPTY/FULL encoding of the single-entry output slot
//   clog2    - index width helper (never returns less than 1)
//   SATCNT_W - width of the optional saturation event counter
package ceiling_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int SATCNT_W = 16;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin grant selection.
// Ports:
//   req     [N-1:0]   - request vector
//   ptr     [IDW-1:0] - index holding highest priority this cycle
//   en                - grant enable; no grant is issued while low
//   gnt     [N-1:0]   - one-hot grant (zero when disabled or no request)
//   gnt_idx [IDW-1:0] - binary index of the granted requester
module rr_arbiter
    import ceiling_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    int   idx;
    logic any_req;

    // Walk offsets from farthest to nearest so the last hit, the one
    // closest to ptr, wins.
    always_comb begin
        idx     = 0;
        any_req = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (req[idx]) begin
                any_req = 1'b1;
                gnt_idx = IDW'(idx);
            end
        end
        if (en && any_req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/ceiling_arbiter.sv
// ceiling_arbiter
// Round-robin arbiter in front of a single-entry registered output slot.
// The granted request is range-checked: if its top CSIZE bits are clear the
// next OSIZE bits are forwarded, otherwise the result saturates to all ones.
//
// Handshake: a request transfers when req_valid[i] && req_ready[i]; a
// result transfers when out_valid && out_ready. req_ready is combinational
// and only asserted while the slot is free (EMPTY, or FULL and draining this
// cycle) and rst_n is high.
//
// Ports:
//   clock, rst_n          - clock, asynchronous active-low reset
//   req_valid [NREQ]      - per-requester valid
//   req_data  [NREQ*DSIZE]- requester i at [i*DSIZE +: DSIZE]
//   req_ready [NREQ]      - one-hot grant
//   out_valid/out_ready   - result handshake (out_valid mirrors FULL state)
//   out_data  [OSIZE]     - truncated or saturated result
//   out_id    [IDW]       - requester that produced out_data
//   out_sat               - result was saturated
//   sat_clr, sat_cnt[16]  - only with CEILING_ARBITER_SATCNT_EN defined:
//                           sticky count of saturated result transfers
module ceiling_arbiter
    import ceiling_arb_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int CSIZE = 4,
    parameter int OSIZE = 8,
    parameter int NREQ  = 4
) (
    input  logic                     clock,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DSIZE-1:0]    req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OSIZE-1:0]         out_data,
    output logic [clog2(NREQ)-1:0]   out_id,
`ifdef CEILING_ARBITER_SATCNT_EN
    input  logic                     sat_clr,
    output logic [SATCNT_W-1:0]      sat_cnt,
`endif
    output logic                     out_sat
);

    localparam int IDW = clog2(NREQ);

    state_e           state_q, state_d;
    logic [OSIZE-1:0] out_data_q, out_data_d;
    logic [IDW-1:0]   out_id_q, out_id_d;
    logic             out_sat_q, out_sat_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic             slot_free;
    logic             arb_en;
    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             req_xfer;
    logic             out_xfer;
    logic [DSIZE-1:0] sel_data;
    logic [OSIZE-1:0] res_data;
    logic             res_sat;
    logic             unused_sel;

    assign slot_free = (state_q == ST_EMPTY) || out_ready;
    // Gating with rst_n keeps req_ready low during reset even though the
    // grant path itself is combinational.
    assign arb_en    = rst_n && slot_free;

    rr_arbiter #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    // Grants only go to valid requesters, so any grant is a transfer.
    assign req_xfer  = |gnt;
    assign out_xfer  = (state_q == ST_FULL) && out_ready;

    assign sel_data  = req_data[int'(gnt_idx)*DSIZE +: DSIZE];
    // Bits below the forwarded window are intentionally dropped.
    assign unused_sel = &{1'b0, sel_data};

    always_comb begin
        res_sat  = 1'b1;
        res_data = '1;
        if (sel_data[DSIZE-1 -: CSIZE] == '0) begin
            res_sat  = 1'b0;
            res_data = sel_data[DSIZE-1-CSIZE -: OSIZE];
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        out_sat_d  = out_sat_q;
        ptr_d      = ptr_q;
        if (req_xfer) begin
            // Covers both EMPTY->FULL and FULL->FULL with simultaneous drain.
            state_d    = ST_FULL;
            out_data_d = res_data;
            out_id_d   = gnt_idx;
            out_sat_d  = res_sat;
            ptr_d      = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end else if (out_xfer) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            out_data_q <= '0;
            out_id_q   <= '0;
            out_sat_q  <= 1'b0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            out_sat_q  <= out_sat_d;
            ptr_q      <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_sat   = out_sat_q;

`ifdef CEILING_ARBITER_SATCNT_EN
    logic [SATCNT_W-1:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_xfer && out_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_ceiling_arbiter.sv
// tb_ceiling_arbiter
// Directed and random stimulus for ceiling_arbiter (DSIZE=16, CSIZE=4,
// OSIZE=8, NREQ=4). A negedge monitor runs a reference model of the grant
// and slot behaviour; results are pushed to exp_q on modelled request
// transfers and compared while the slot is full, popped on output transfer.
// Counter checks run only when CEILING_ARBITER_SATCNT_EN is defined.
module tb_ceiling_arbiter;

    localparam int DSIZE = 16;
    localparam int CSIZE = 4;
    localparam int OSIZE = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int EW    = IDW + 1 + OSIZE;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic                  out_ready;
    logic [OSIZE-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_sat;
`ifdef CEILING_ARBITER_SATCNT_EN
    logic                  sat_clr;
    logic [15:0]           sat_cnt;
`endif

    ceiling_arbiter #(
        .DSIZE (DSIZE),
        .CSIZE (CSIZE),
        .OSIZE (OSIZE),
        .NREQ  (NREQ)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
`ifdef CEILING_ARBITER_SATCNT_EN
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt),
`endif
        .out_sat   (out_sat)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [OSIZE:0] model_result(input logic [DSIZE-1:0] d);
        if (d[15:12] == 4'h0) return {1'b0, d[11:4]};
        return {1'b1, 8'hFF};
    endfunction

    function automatic int model_pick(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [EW-1:0] exp_q[$];
    logic          m_full = 1'b0;
    int            m_ptr  = 0;

    always @(negedge clock) begin
        int            pick;
        logic [NREQ-1:0] exp_rdy;
        logic [OSIZE:0]  r;
        if (!rst_n) begin
            m_full = 1'b0;
            m_ptr  = 0;
            exp_q.delete();
            check_val("mon_rst_vld", 32'(out_valid), 32'd0);
            check_val("mon_rst_rdy", 32'(req_ready), 32'd0);
            check_val("mon_rst_data", 32'(out_data), 32'd0);
        end else begin
            pick    = model_pick(req_valid, m_ptr);
            exp_rdy = '0;
            if (pick >= 0 && (!m_full || out_ready)) exp_rdy[pick] = 1'b1;
            check_val("mon_rdy", 32'(req_ready), 32'(exp_rdy));
            check_val("mon_vld", 32'(out_valid), 32'(m_full));
            if (m_full) begin
                if (exp_q.size() == 0) begin
                    check_val("mon_sb_empty", 32'd1, 32'd0);
                end else begin
                    check_val("mon_res", 32'({out_id, out_sat, out_data}), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (exp_rdy != '0) begin
                r = model_result(req_data[pick*DSIZE +: DSIZE]);
                exp_q.push_back({IDW'(pick), r});
                m_full = 1'b1;
                m_ptr  = (pick + 1) % NREQ;
            end else if (m_full && out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [DSIZE-1:0] d);
        req_data[i*DSIZE +: DSIZE] = d;
    endtask

    function automatic logic [DSIZE-1:0] rand_word();
        if ($urandom_range(0, 1) == 1) return {4'h0, 12'($urandom)};
        return 16'($urandom);
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
`ifdef CEILING_ARBITER_SATCNT_EN
        sat_clr   = 1'b0;
`endif
        #2;
        req_valid = 4'hF;
        #1;
        check_val("rst_rdy", 32'(req_ready), 32'd0);
        check_val("rst_vld", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);
        check_val("rst_id", 32'(out_id), 32'd0);
        check_val("rst_sat", 32'(out_sat), 32'd0);
        req_valid = '0;
        step();
        step();
        rst_n = 1'b1;

        // saturation datapath
        set_req(0, 16'h0ABC);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        #1;
        check_val("sat_rdy", 32'(req_ready), 32'h1);
        step();
        check_val("pass_vld", 32'(out_valid), 32'd1);
        check_val("pass_data", 32'(out_data), 32'hAB);
        check_val("pass_id", 32'(out_id), 32'd0);
        check_val("pass_sat", 32'(out_sat), 32'd0);
        set_req(0, 16'h1234);
        #1;
        check_val("single_rdy", 32'(req_ready), 32'h1);
        step();
        check_val("clip_data", 32'(out_data), 32'hFF);
        check_val("clip_sat", 32'(out_sat), 32'd1);
        req_valid = '0;
        step();
        check_val("drain_vld", 32'(out_valid), 32'd0);

        // round robin from a fresh pointer
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, {4'h0, 8'(8'h10 + i), 4'h0});
        req_valid = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("rr_gnt", 32'(req_ready), 32'(1 << (k % NREQ)));
            step();
            check_val("rr_id", 32'(out_id), 32'(k % NREQ));
            check_val("rr_data", 32'(out_data), 32'(8'h10 + (k % NREQ)));
        end

        // backpressure
        req_valid = '0;
        do_reset();
        set_req(0, 16'h05A0);
        set_req(1, 16'h0330);
        req_valid = 4'b0001;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_val("bp_rdy", 32'(req_ready), 32'd0);
            check_val("bp_vld", 32'(out_valid), 32'd1);
            check_val("bp_data", 32'(out_data), 32'h5A);
            check_val("bp_id", 32'(out_id), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check_val("bp_release_rdy", 32'(req_ready), 32'h2);
        step();
        check_val("bp_next_vld", 32'(out_valid), 32'd1);
        check_val("bp_next_data", 32'(out_data), 32'h33);
        check_val("bp_next_id", 32'(out_id), 32'd1);

        // reset while FULL
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_vld", 32'(out_valid), 32'd0);
        check_val("mid_rst_rdy", 32'(req_ready), 32'd0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_val("post_rst_vld", 32'(out_valid), 32'd0);
        end

        // random traffic, checked by the monitor
        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < NREQ; i++) set_req(i, rand_word());
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        out_ready = 1'b1;
        step();
        step();
        check_val("rand_drain_vld", 32'(out_valid), 32'd0);

`ifdef CEILING_ARBITER_SATCNT_EN
        do_reset();
        check_val("cnt_rst", 32'(sat_cnt), 32'd0);
        set_req(0, 16'hF000);
        req_valid = 4'b0001;
        step();
        step();
        step();
        req_valid = '0;
        step();
        step();
        check_val("cnt_three", 32'(sat_cnt), 32'd3);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        sat_clr   = 1'b1;
        step();
        sat_clr   = 1'b0;
        check_val("cnt_clr", 32'(sat_cnt), 32'd0);
        req_valid = 4'b0001;
        for (int n = 0; n < 65540; n++) step();
        req_valid = '0;
        step();
        step();
        check_val("cnt_stick", 32'(sat_cnt), 32'hFFFF);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        step();
        check_val("cnt_stick2", 32'(sat_cnt), 32'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
